// File: rtl/clk_div_multi_if.sv
// Configuration and output bundle for the multi-channel clock-enable divider.
// Optional macro CLK_DIV_PHASE_SYNC_EN adds the sync_all phase-alignment input.
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26
);
    logic [NUM_CH-1:0] en;
    logic              cfg_we;
    logic [3:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
`ifdef CLK_DIV_PHASE_SYNC_EN
    logic              sync_all;
`endif
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] cfg_pending;

    // Controller side: drives enables and config, observes the divided outputs.
    modport master (
        output en, cfg_we, cfg_ch, cfg_half,
`ifdef CLK_DIV_PHASE_SYNC_EN
        output sync_all,
`endif
        input  clk_out, tick, cfg_pending
    );

    // Divider side.
    modport slave (
        input  en, cfg_we, cfg_ch, cfg_half,
`ifdef CLK_DIV_PHASE_SYNC_EN
        input  sync_all,
`endif
        output clk_out, tick, cfg_pending
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider.
// Each channel produces a 50% duty square wave of period 2*H system clocks and
// a one-cycle tick on every rising toggle. A new half-period is staged in a
// shadow register and takes effect at the end of a full period (falling toggle),
// or immediately while the channel is disabled. A half-period of 0 acts as 1.
// Optional macro CLK_DIV_PHASE_SYNC_EN adds sync_all, which restarts all channels
// in phase and applies any staged half-periods.
module clk_div_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 26,
    parameter int DEF_HALF = 25000000
) (
    input  logic            clk,
    input  logic            rst,
    clk_div_multi_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HALF);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_half;
        logic [CNT_W-1:0] shd_half;
        logic             out_q;
        logic             tick_q;
        logic             pend_q;
        logic [CNT_W-1:0] last_cnt;
        logic             wr;
        logic             at_end;

        // Terminal count of the current half period and write-select decode.
        always_comb begin
            last_cnt = (act_half == '0) ? '0 : act_half - CNT_W'(1);
            wr       = bus.cfg_we && (bus.cfg_ch == 4'(g));
            at_end   = (cnt == last_cnt);
        end

        // Per-channel counter, output toggle, tick strobe and shadow/active update.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt      <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
                act_half <= DEF_H;
                shd_half <= DEF_H;
            end
`ifdef CLK_DIV_PHASE_SYNC_EN
            else if (bus.sync_all) begin
                // Restart in phase; the previously staged value is applied, while a
                // write landing on this edge is captured and stays pending.
                cnt      <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
                act_half <= shd_half;
                if (wr) begin
                    shd_half <= bus.cfg_half;
                    pend_q   <= 1'b1;
                end else begin
                    pend_q   <= 1'b0;
                end
            end
`endif
            else if (!bus.en[g]) begin
                // Idle channel: nothing to protect, so staged values apply at once.
                cnt    <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                pend_q <= 1'b0;
                if (wr) begin
                    shd_half <= bus.cfg_half;
                    act_half <= bus.cfg_half;
                end else begin
                    act_half <= shd_half;
                end
            end else begin
                tick_q <= at_end && !out_q;
                if (at_end) begin
                    cnt   <= '0;
                    out_q <= !out_q;
                end else begin
                    cnt   <= cnt + CNT_W'(1);
                end
                if (at_end && out_q) begin
                    // End of a full period: the apply point. A write on this very
                    // edge takes precedence over the older shadow contents.
                    pend_q <= 1'b0;
                    if (wr) begin
                        shd_half <= bus.cfg_half;
                        act_half <= bus.cfg_half;
                    end else begin
                        act_half <= shd_half;
                    end
                end else if (wr) begin
                    shd_half <= bus.cfg_half;
                    pend_q   <= 1'b1;
                end
            end
        end

        assign bus.clk_out[g]     = out_q;
        assign bus.tick[g]        = tick_q;
        assign bus.cfg_pending[g] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed testbench for clk_div_multi: two channels, default half-period 3.
// Optional macro CLK_DIV_PHASE_SYNC_EN enables the phase-sync sequence.
module tb_clk_div_multi;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic sync_v = 1'b0;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [1:0] en;
        logic       we;
        logic [3:0] ch;
        logic [7:0] half;
        logic [1:0] e_out;
        logic [1:0] e_tick;
        logic [1:0] e_pend;
    } vec_t;

    vec_t vt [28];

    function automatic vec_t mk(input logic r, input logic [1:0] en, input logic we,
                                input logic [3:0] ch, input logic [7:0] half,
                                input logic [1:0] eo, input logic [1:0] et,
                                input logic [1:0] ep);
        vec_t v;
        v.r = r; v.en = en; v.we = we; v.ch = ch; v.half = half;
        v.e_out = eo; v.e_tick = et; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one set of inputs across a rising edge, then settle for sampling.
    task automatic step(input logic r, input logic [1:0] e, input logic w,
                        input logic [3:0] c, input logic [7:0] h);
        rst          = r;
        bus.en       = e;
        bus.cfg_we   = w;
        bus.cfg_ch   = c;
        bus.cfg_half = h;
`ifdef CLK_DIV_PHASE_SYNC_EN
        bus.sync_all = sync_v;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 2'b00, 1'b0, 4'd0, 8'd0);
        step(1'b1, 2'b00, 1'b0, 4'd0, 8'd0);
    endtask

    // Expect channel ch to stay low for n-1 edges and rise with a tick on edge n.
    task automatic rise_after(input int ch, input int n, input logic [1:0] e, input string nm);
        for (int k = 1; k <= n; k++) begin
            step(1'b0, e, 1'b0, 4'd0, 8'd0);
            if (k < n) begin
                chk({nm, "_low"}, 32'(bus.clk_out[ch]), 32'd0);
            end else begin
                chk({nm, "_rise"}, 32'(bus.clk_out[ch]), 32'd1);
                chk({nm, "_tick"}, 32'(bus.tick[ch]), 32'd1);
            end
        end
    endtask

    // Wait (bounded) for ch1 to apply its shadow, then check the clk/2 waveform.
    task automatic check_fast_ch1(input string nm);
        logic ok;
        logic e;
        ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (!bus.cfg_pending[1]) begin
                ok = 1'b1;
                break;
            end
            step(1'b0, 2'b11, 1'b0, 4'd0, 8'd0);
        end
        chk({nm, "_apply_timeout"}, 32'(ok), 32'd1);
        e = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 2'b11, 1'b0, 4'd0, 8'd0);
            e = ~e;
            chk({nm, "_out"}, 32'(bus.clk_out[1]), 32'(e));
            chk({nm, "_tick"}, 32'(bus.tick[1]), 32'(e));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset, free run, mid-high reload of ch0, ignored write, reset with pending.
        vt[0]  = mk(1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[1]  = mk(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[2]  = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[3]  = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[4]  = mk(0, 2'b11, 0, 0, 0, 2'b11, 2'b11, 2'b00);
        vt[5]  = mk(0, 2'b11, 1, 0, 5, 2'b11, 2'b00, 2'b01);
        vt[6]  = mk(0, 2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b01);
        vt[7]  = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[8]  = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[9]  = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[10] = mk(0, 2'b11, 0, 0, 0, 2'b10, 2'b10, 2'b00);
        vt[11] = mk(0, 2'b11, 0, 0, 0, 2'b10, 2'b00, 2'b00);
        vt[12] = mk(0, 2'b11, 0, 0, 0, 2'b11, 2'b01, 2'b00);
        vt[13] = mk(0, 2'b11, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        vt[14] = mk(0, 2'b11, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        vt[15] = mk(0, 2'b11, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        vt[16] = mk(0, 2'b11, 0, 0, 0, 2'b11, 2'b10, 2'b00);
        vt[17] = mk(0, 2'b11, 0, 0, 0, 2'b10, 2'b00, 2'b00);
        vt[18] = mk(0, 2'b11, 0, 0, 0, 2'b10, 2'b00, 2'b00);
        vt[19] = mk(0, 2'b11, 1, 7, 1, 2'b00, 2'b00, 2'b00);
        vt[20] = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[21] = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[22] = mk(0, 2'b11, 1, 1, 2, 2'b11, 2'b11, 2'b10);
        vt[23] = mk(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[24] = mk(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[25] = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[26] = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        vt[27] = mk(0, 2'b11, 0, 0, 0, 2'b11, 2'b11, 2'b00);

        for (int i = 0; i < 28; i++) begin
            step(vt[i].r, vt[i].en, vt[i].we, vt[i].ch, vt[i].half);
            chk($sformatf("vec%0d_clk_out", i), 32'(bus.clk_out), 32'(vt[i].e_out));
            chk($sformatf("vec%0d_tick", i), 32'(bus.tick), 32'(vt[i].e_tick));
            chk($sformatf("vec%0d_pending", i), 32'(bus.cfg_pending), 32'(vt[i].e_pend));
        end

        // Half-period 0 on ch1 behaves as 1: toggle every cycle.
        do_reset();
        step(1'b0, 2'b11, 1'b1, 4'd1, 8'd0);
        chk("half0_pending", 32'(bus.cfg_pending), 32'h2);
        check_fast_ch1("half0");
        // Half-period 1 gives the identical waveform.
        step(1'b0, 2'b11, 1'b1, 4'd1, 8'd1);
        check_fast_ch1("half1");

        // Enable drop mid-high phase, re-raise, and write while disabled.
        do_reset();
        rise_after(0, 3, 2'b11, "start");
        step(1'b0, 2'b10, 1'b0, 4'd0, 8'd0);
        chk("drop_clk_out", 32'(bus.clk_out), 32'h2);
        chk("drop_tick", 32'(bus.tick), 32'h0);
        rise_after(0, 3, 2'b11, "reraise");
        step(1'b0, 2'b10, 1'b1, 4'd0, 8'd4);
        chk("dis_write_pending", 32'(bus.cfg_pending[0]), 32'd0);
        chk("dis_write_clk_out", 32'(bus.clk_out[0]), 32'd0);
        rise_after(0, 4, 2'b11, "dis_write");

`ifdef CLK_DIV_PHASE_SYNC_EN
        // Channels offset by two cycles, then realigned by sync_all.
        do_reset();
        step(1'b0, 2'b01, 1'b0, 4'd0, 8'd0);
        step(1'b0, 2'b01, 1'b0, 4'd0, 8'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 2'b11, 1'b0, 4'd0, 8'd0);
        sync_v = 1'b1;
        step(1'b0, 2'b11, 1'b1, 4'd0, 8'd3);
        sync_v = 1'b0;
        chk("sync_clk_out", 32'(bus.clk_out), 32'h0);
        chk("sync_tick", 32'(bus.tick), 32'h0);
        chk("sync_pending", 32'(bus.cfg_pending), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 2'b11, 1'b0, 4'd0, 8'd0);
            if (k < 3) begin
                chk("sync_low", 32'(bus.clk_out), 32'h0);
            end else begin
                chk("sync_rise", 32'(bus.clk_out), 32'h3);
                chk("sync_rise_tick", 32'(bus.tick), 32'h3);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel programmable clock-enable divider; next generation of the fixed 50 MHz to 1 Hz divider.
- Generates NUM_CH independent square-wave outputs plus single-cycle tick strobes from one system clock.
- Each channel's half-period is loaded at runtime through a shadow register and applied glitch-free at a period boundary.
- Sits between the system clock and LED/blink/timebase consumers; outputs are logic signals, not routed clocks.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 26, width of the half-period counter and registers
DEF_HALF, 25000000, reset half-period in clk cycles (50 MHz to 1 Hz)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
en  input  NUM_CH  per-channel run enable
cfg_we  input  1  config write strobe, one cycle
cfg_ch  input  4  target channel of the write
cfg_half  input  CNT_W  new half-period value
clk_out  output  NUM_CH  divided square wave per channel
tick  output  NUM_CH  one-cycle pulse on each clk_out rising edge
cfg_pending  output  NUM_CH  shadow value written but not yet applied

Behaviour:
- Reset state (rst=1 at a clk edge): cnt=0, clk_out=0, tick=0, cfg_pending=0, active half = shadow half = DEF_HALF for every channel. rst overrides all other inputs.
- Effective half H = active half, with a value of 0 treated as 1.
- Running channel (en[i]=1) at each edge:
  - If cnt == H-1: cnt<=0 and clk_out toggles.
  - Otherwise: cnt<=cnt+1.
- Timing: first toggle occurs on the H-th edge after rst release or en rise. Period is 2H cycles, duty exactly 50%.
- tick[i]: registered. High for exactly one cycle, the same cycle clk_out[i] becomes 1. Low otherwise, including on the falling toggle.
- Disabled channel (en[i]=0): cnt<=0, clk_out<=0, tick<=0. Any pending shadow is applied immediately and cfg_pending clears.
  - Dropping en mid-period truncates the high phase with no tick.
- Config write (cfg_we=1, cfg_ch<NUM_CH): shadow[cfg_ch]<=cfg_half and cfg_pending[cfg_ch]<=1 on that edge.
  - cfg_ch>=NUM_CH: write ignored, no state change.
- Apply point for an enabled channel: the edge where clk_out goes 1->0, i.e. end of a full period.
  - On that edge, active<=shadow and cfg_pending clears. The new H governs counting from the following cycle.
  - Mid-period writes never alter the current period.
- Simultaneous write and apply edge on the same channel: the write wins. Shadow takes the new value, active takes the new value too, and cfg_pending ends at 0.
- Back-to-back writes before apply: last value wins.
- Channels are fully independent; no shared state other than the config bus.

Optional Feature:
Macro: CLK_DIV_PHASE_SYNC_EN
- When defined:
  - Adds input port sync_all (1 bit).
  - sync_all=1 at an edge forces, for all channels: cnt<=0, clk_out<=0, tick<=0, pending shadows applied, cfg_pending cleared.
  - Effect is identical for enabled and disabled channels. Enabled channels then restart in phase, with the first toggle H edges later.
  - rst has priority over sync_all. sync_all has priority over a simultaneous cfg_we for the apply step; the written shadow is still captured and leaves cfg_pending=1.
- When undefined: no sync_all port; behaviour exactly as above.

Test Plan:
- Reset value: NUM_CH=2, DEF_HALF=3. Hold rst 2 cycles -> clk_out=00, tick=00, cfg_pending=00. Release with en=11 -> clk_out rises on edge 3; period 6 cycles; tick high 1 cycle per 6.
- Runtime reload: with DEF_HALF=3, write cfg_ch=0, cfg_half=5 mid-high-phase -> cfg_pending[0]=1, current period stays 6 cycles. After the next falling edge the period is 10 cycles and cfg_pending[0]=0. Channel 1 is unaffected.
- Zero/one half: write cfg_half=0 on ch1 -> after apply, clk_out[1] toggles every cycle (clk/2) and tick[1] is high every other cycle. Write cfg_half=1 -> identical waveform.
- Enable/write edge cases:
  - Drop en[0] mid-high phase -> clk_out[0]=0 next edge, no tick. Re-raise -> first rise H edges later.
  - Write while disabled -> applied at once, cfg_pending=0.
  - Write to cfg_ch=7 -> no change on any output.
- Reset mid-operation: assert rst while clk_out=11 with pending writes -> next edge clk_out=00, cfg_pending=00, H back to DEF_HALF.
- Phase sync (with CLK_DIV_PHASE_SYNC_EN): ch0 H=3, ch1 H=3, offset by 2 cycles; pulse sync_all -> both clk_out=0 next edge, then rise together 3 edges later.
